eth_rx_block_lock: RTL and testbench
====================================

Name: eth_rx_block_lock

Overview:
- Parametrised multi-lane 64b/66b block-lock engine for the 10G receive path.
- Sits between the GTX wrapper (RX header outputs, gearbox mode) and the PCS descrambler.
- Per lane, runs a Clause-49-style lock state machine and drives the GTX RXSLIP input until sync headers align.
- Reports lock status and saturating slip and lock-loss counters per lane to the debug bus.

Parameters:
- NUM_LANES, 1, number of independent GTX lanes handled.
- LOCK_COUNT, 64, consecutive valid headers required to declare lock; also the window length while locked.
- INVALID_LIMIT, 16, invalid headers within one LOCK_COUNT window that force loss of lock.
- SLIP_WAIT_CYCLES, 32, cycles held after each slip pulse before header testing resumes (GTX requires ≥32 RXUSRCLK2 cycles between slips).
- CNT_WIDTH, 16, width of the per-lane saturating statistics counters.

Ports:
- i_clk  input  1  RX user clock (RXUSRCLK2); all lanes share it.
- i_rst  input  1  reset, synchronous, active-high.
- i_rxheader  input  2*NUM_LANES  sync header per lane; lane n occupies bits [2n+1:2n].
- i_rxheader_valid  input  NUM_LANES  header qualifier per lane.
- o_rxslip  output  NUM_LANES  one-cycle slip request to the GTX, per lane.
- o_block_lock  output  NUM_LANES  lane is block-locked.
- o_slip_count  output  CNT_WIDTH*NUM_LANES  saturating count of slips issued, per lane.
- o_lock_loss_count  output  CNT_WIDTH*NUM_LANES  saturating count of LOCKED→unlocked transitions, per lane.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; every lane in state TEST, with sh_cnt = 0, inv_cnt = 0 and wait_cnt = 0.
- Header validity: a header is valid iff it equals 2'b01 or 2'b10. Headers 2'b00 and 2'b11 are invalid.
- Header events: only cycles with i_rxheader_valid[n] = 1 count as header events. Other cycles leave the lane's counters unchanged.
- Lanes: each lane is fully independent; there is no cross-lane interaction.
- State TEST (unlocked):
  - Invalid header event → next state SLIP.
  - Valid header event → sh_cnt + 1.
  - When sh_cnt reaches LOCK_COUNT → next state LOCKED; sh_cnt and inv_cnt cleared; o_block_lock = 1 from the next cycle.
- State SLIP:
  - o_rxslip[n] = 1 for exactly this one cycle; slip_count incremented (saturating).
  - Next state WAIT with wait_cnt loaded to SLIP_WAIT_CYCLES-1.
- State WAIT:
  - Header events are ignored; wait_cnt decrements each cycle.
  - At 0 → clear sh_cnt and inv_cnt, next state TEST.
  - Minimum spacing between slip pulses is therefore SLIP_WAIT_CYCLES+1 cycles.
- State LOCKED (o_block_lock = 1):
  - Each header event → sh_cnt + 1; an invalid header also → inv_cnt + 1.
  - If inv_cnt reaches INVALID_LIMIT → o_block_lock drops next cycle; lock_loss_count + 1 (saturating); next state SLIP.
  - Otherwise, if sh_cnt reaches LOCK_COUNT → both counters clear and the lane stays LOCKED.
  - Simultaneous case: if the invalid header is also the LOCK_COUNT-th header, the loss-of-lock check wins.
- o_block_lock is registered and equals (state == LOCKED).
- Latency: header event to o_rxslip assertion = 1 cycle (TEST → SLIP registered).
- Counter saturation: slip_count and lock_loss_count hold at 2^CNT_WIDTH-1 and never wrap.
- Internal counters: sh_cnt is sized $clog2(LOCK_COUNT+1) bits; inv_cnt is sized $clog2(INVALID_LIMIT+1) bits.
- Reset mid-operation: any state, including mid-WAIT or on the o_rxslip cycle, returns to reset values on the next edge. No further slip is issued.
- Statistics survive no reset other than i_rst.

Decomposition:
- Package eth_pcs_pkg:
  - SYNC_HDR_DATA = 2'b01 and SYNC_HDR_CTRL = 2'b10.
  - Enum block_lock_state_t {TEST, SLIP, WAIT, LOCKED}.
  - Function is_valid_sync_hdr.
- Sub-module eth_rx_block_lock_lane: single-lane FSM plus counters.
  - Instantiated NUM_LANES times in a generate loop.
  - The top only slices buses.

Test Plan:
- Reset, then 64 valid headers (alternating 01/10) on lane 0 → o_block_lock[0] rises the cycle after the 64th; o_rxslip never asserted; o_slip_count = 0.
- Header 2'b11 at event 10 while unlocked → o_rxslip pulses 1 cycle, 1 cycle after that event. Header events for the next 32 cycles are ignored. slip_count = 1. A second invalid header right after WAIT gives a slip spacing of exactly 33 cycles.
- Locked lane, 15 invalid headers within one 64-header window → stays locked. Exactly 16 invalid headers in a window → lock drops, lock_loss_count = 1, slip pulse follows.
- 16th invalid header arrives as the 64th header of the window → lock lost (priority check).
- NUM_LANES = 4: lane 2 fed invalid headers only, lanes 0, 1 and 3 fed valid headers → lanes 0, 1 and 3 lock; lane 2 slips every 33 cycles; its slip_count increments; other lanes' counts stay 0.
- CNT_WIDTH = 4, continuous invalid headers → slip_count saturates at 15. Assert i_rst during WAIT → all outputs 0 the next cycle and no stray o_rxslip.

Source files
------------

// File: rtl/eth_pcs_pkg.sv
// Shared definitions for the 10G PCS receive path.
//   SYNC_HDR_DATA / SYNC_HDR_CTRL : the two legal 64b/66b sync headers
//   block_lock_state_t            : per-lane block-lock state encoding
//   is_valid_sync_hdr()           : 1 when a 2-bit header is a legal sync header
package eth_pcs_pkg;

    localparam logic [1:0] SYNC_HDR_DATA = 2'b01;
    localparam logic [1:0] SYNC_HDR_CTRL = 2'b10;

    typedef enum logic [1:0] {
        TEST   = 2'd0,
        SLIP   = 2'd1,
        WAIT   = 2'd2,
        LOCKED = 2'd3
    } block_lock_state_t;

    function automatic logic is_valid_sync_hdr(input logic [1:0] hdr);
        return (hdr == SYNC_HDR_DATA) || (hdr == SYNC_HDR_CTRL);
    endfunction

endpackage

// File: rtl/eth_rx_block_lock_lane.sv
// Single-lane 64b/66b block-lock state machine with statistics counters.
//   clk, rst            : RX user clock, synchronous active-high reset
//   rxheader            : 2-bit sync header for this lane
//   rxheader_valid      : header qualifier; a cycle with rxheader_valid = 1 is
//                         one header event, other cycles carry no header. There
//                         is no ready/backpressure: every qualified header is
//                         consumed in the cycle it is presented.
//   state               : current lock state (registered); the top decodes
//                         o_rxslip / o_block_lock from it
//   slip_count          : saturating count of slip pulses issued
//   lock_loss_count     : saturating count of LOCKED -> SLIP transitions
module eth_rx_block_lock_lane
    import eth_pcs_pkg::*;
#(
    parameter int LOCK_COUNT       = 64,
    parameter int INVALID_LIMIT    = 16,
    parameter int SLIP_WAIT_CYCLES = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           rxheader,
    input  logic                 rxheader_valid,
    output block_lock_state_t    state,
    output logic [CNT_WIDTH-1:0] slip_count,
    output logic [CNT_WIDTH-1:0] lock_loss_count
);

    localparam int SH_W  = $clog2(LOCK_COUNT + 1);
    localparam int INV_W = $clog2(INVALID_LIMIT + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [SH_W-1:0]  LOCK_V      = SH_W'(LOCK_COUNT);
    localparam logic [INV_W-1:0] INV_V       = INV_W'(INVALID_LIMIT);
    localparam logic [WT_W-1:0]  WAIT_LOAD   = WT_W'(SLIP_WAIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    block_lock_state_t    state_q, state_d;
    logic [SH_W-1:0]      sh_q, sh_d, sh_inc;
    logic [INV_W-1:0]     inv_q, inv_d, inv_nxt;
    logic [WT_W-1:0]      wait_q, wait_d;
    logic [CNT_WIDTH-1:0] slip_q, loss_q;
    logic                 slip_inc, loss_inc, hdr_ok;

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        inv_d    = inv_q;
        wait_d   = wait_q;
        slip_inc = 1'b0;
        loss_inc = 1'b0;
        hdr_ok   = is_valid_sync_hdr(rxheader);
        sh_inc   = sh_q + SH_W'(1);
        inv_nxt  = hdr_ok ? inv_q : inv_q + INV_W'(1);

        case (state_q)
            TEST: begin
                if (rxheader_valid) begin
                    if (!hdr_ok) begin
                        state_d = SLIP;
                    end else if (sh_inc == LOCK_V) begin
                        state_d = LOCKED;
                        sh_d    = '0;
                        inv_d   = '0;
                    end else begin
                        sh_d = sh_inc;
                    end
                end
            end
            SLIP: begin
                slip_inc = 1'b1;
                wait_d   = WAIT_LOAD;
                state_d  = WAIT;
            end
            WAIT: begin
                // Leave on the cycle the counter steps down to zero, so the
                // first TEST cycle is SLIP_WAIT_CYCLES cycles after the pulse
                // and back-to-back slips are SLIP_WAIT_CYCLES+1 apart.
                if (wait_q <= WT_W'(1)) begin
                    state_d = TEST;
                    wait_d  = '0;
                    sh_d    = '0;
                    inv_d   = '0;
                end else begin
                    wait_d = wait_q - WT_W'(1);
                end
            end
            LOCKED: begin
                if (rxheader_valid) begin
                    // Loss of lock is tested before window completion so an
                    // invalid header that is also the last of the window
                    // still drops lock.
                    if (inv_nxt == INV_V) begin
                        state_d  = SLIP;
                        loss_inc = 1'b1;
                        sh_d     = '0;
                        inv_d    = '0;
                    end else if (sh_inc == LOCK_V) begin
                        sh_d  = '0;
                        inv_d = '0;
                    end else begin
                        sh_d  = sh_inc;
                        inv_d = inv_nxt;
                    end
                end
            end
            default: state_d = TEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TEST;
            sh_q    <= '0;
            inv_q   <= '0;
            wait_q  <= '0;
            slip_q  <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            inv_q   <= inv_d;
            wait_q  <= wait_d;
            if (slip_inc && (slip_q != '1)) slip_q <= slip_q + CNT_ONE;
            if (loss_inc && (loss_q != '1)) loss_q <= loss_q + CNT_ONE;
        end
    end

    assign state           = state_q;
    assign slip_count      = slip_q;
    assign lock_loss_count = loss_q;

endmodule

// File: rtl/eth_rx_block_lock.sv
// Multi-lane 64b/66b block-lock engine between the GTX wrapper and the
// descrambler. One independent lock FSM per lane; this level only slices
// the lane buses and decodes the registered lane state.
//   i_clk, i_rst        : RXUSRCLK2, synchronous active-high reset
//   i_rxheader          : lane n header on bits [2n+1:2n]
//   i_rxheader_valid    : per-lane header qualifier (no backpressure)
//   o_rxslip            : one-cycle GTX RXSLIP request per lane
//   o_block_lock        : lane is block-locked
//   o_slip_count        : lane n on bits [CNT_WIDTH*(n+1)-1:CNT_WIDTH*n]
//   o_lock_loss_count   : same packing as o_slip_count
module eth_rx_block_lock
    import eth_pcs_pkg::*;
#(
    parameter int NUM_LANES        = 1,
    parameter int LOCK_COUNT       = 64,
    parameter int INVALID_LIMIT    = 16,
    parameter int SLIP_WAIT_CYCLES = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [2*NUM_LANES-1:0]         i_rxheader,
    input  logic [NUM_LANES-1:0]           i_rxheader_valid,
    output logic [NUM_LANES-1:0]           o_rxslip,
    output logic [NUM_LANES-1:0]           o_block_lock,
    output logic [CNT_WIDTH*NUM_LANES-1:0] o_slip_count,
    output logic [CNT_WIDTH*NUM_LANES-1:0] o_lock_loss_count
);

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        block_lock_state_t lane_state;

        eth_rx_block_lock_lane #(
            .LOCK_COUNT       (LOCK_COUNT),
            .INVALID_LIMIT    (INVALID_LIMIT),
            .SLIP_WAIT_CYCLES (SLIP_WAIT_CYCLES),
            .CNT_WIDTH        (CNT_WIDTH)
        ) u_lane (
            .clk             (i_clk),
            .rst             (i_rst),
            .rxheader        (i_rxheader[2*n+1:2*n]),
            .rxheader_valid  (i_rxheader_valid[n]),
            .state           (lane_state),
            .slip_count      (o_slip_count[CNT_WIDTH*n +: CNT_WIDTH]),
            .lock_loss_count (o_lock_loss_count[CNT_WIDTH*n +: CNT_WIDTH])
        );

        // Both are decoded from the lane's state register, so they are
        // glitch-free registered outputs.
        assign o_rxslip[n]     = (lane_state == SLIP);
        assign o_block_lock[n] = (lane_state == LOCKED);
    end

endmodule

// File: tb/tb_eth_rx_block_lock.sv
module tb_eth_rx_block_lock;

  localparam int NL = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2*NL-1:0] rxheader = '0;
  logic [NL-1:0]   rxheader_valid = '0;
  logic [NL-1:0]   rxslip;
  logic [NL-1:0]   block_lock;
  logic [CW*NL-1:0] slip_count;
  logic [CW*NL-1:0] lock_loss_count;

  int n_vec = 0;
  int n_bad = 0;
  logic alt_ph = 1'b0;

  eth_rx_block_lock #(
    .NUM_LANES        (NL),
    .LOCK_COUNT       (64),
    .INVALID_LIMIT    (16),
    .SLIP_WAIT_CYCLES (32),
    .CNT_WIDTH        (CW)
  ) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rxheader        (rxheader),
    .i_rxheader_valid  (rxheader_valid),
    .o_rxslip          (rxslip),
    .o_block_lock      (block_lock),
    .o_slip_count      (slip_count),
    .o_lock_loss_count (lock_loss_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // lane-0 vector: header (or alternating 01/10), qualifier, repeat count,
  // then expected lane-0 outputs after the last repetition
  typedef struct {
    logic [1:0] hdr;
    logic       alt;
    logic       vld;
    int         reps;
    logic       slip;
    logic       lock;
    logic [3:0] sc;
    logic [3:0] ll;
  } vec_t;

  vec_t vecs[23];

  task automatic tick();
    @(posedge clk);
    #1;
    alt_ph = ~alt_ph;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] alt_hdr();
    return alt_ph ? 2'b01 : 2'b10;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    rxheader_valid = '0;
    tick();
    tick();
    check("reset_rxslip", 32'(rxslip), 32'h0);
    check("reset_lock", 32'(block_lock), 32'h0);
    check("reset_slip_count", 32'(slip_count), 32'h0);
    check("reset_loss_count", 32'(lock_loss_count), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_slip;
    logic [3:0]  exp_lock;
    logic [1:0]  hv;

    vecs[0]  = '{2'b00, 1'b1, 1'b1,  9, 1'b0, 1'b0, 4'd0, 4'd0};
    vecs[1]  = '{2'b11, 1'b0, 1'b1,  1, 1'b1, 1'b0, 4'd0, 4'd0}; // 10th event invalid
    vecs[2]  = '{2'b11, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'd1, 4'd0};
    vecs[3]  = '{2'b11, 1'b0, 1'b1, 30, 1'b0, 1'b0, 4'd1, 4'd0}; // ignored in WAIT
    vecs[4]  = '{2'b11, 1'b0, 1'b1,  1, 1'b0, 1'b0, 4'd1, 4'd0}; // back in TEST
    vecs[5]  = '{2'b11, 1'b0, 1'b1,  1, 1'b1, 1'b0, 4'd1, 4'd0}; // 33 after first slip
    vecs[6]  = '{2'b11, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[7]  = '{2'b00, 1'b0, 1'b0, 31, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[8]  = '{2'b00, 1'b1, 1'b1, 63, 1'b0, 1'b0, 4'd2, 4'd0};
    vecs[9]  = '{2'b00, 1'b1, 1'b1,  1, 1'b0, 1'b1, 4'd2, 4'd0}; // 64th valid
    vecs[10] = '{2'b11, 1'b0, 1'b1, 15, 1'b0, 1'b1, 4'd2, 4'd0};
    vecs[11] = '{2'b00, 1'b1, 1'b1, 49, 1'b0, 1'b1, 4'd2, 4'd0}; // window closes
    vecs[12] = '{2'b11, 1'b0, 1'b0,  5, 1'b0, 1'b1, 4'd2, 4'd0}; // unqualified
    vecs[13] = '{2'b00, 1'b0, 1'b1, 15, 1'b0, 1'b1, 4'd2, 4'd0};
    vecs[14] = '{2'b11, 1'b0, 1'b1,  1, 1'b1, 1'b0, 4'd2, 4'd1}; // 16th invalid
    vecs[15] = '{2'b00, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'd3, 4'd1};
    vecs[16] = '{2'b00, 1'b0, 1'b0, 31, 1'b0, 1'b0, 4'd3, 4'd1};
    vecs[17] = '{2'b00, 1'b1, 1'b1, 64, 1'b0, 1'b1, 4'd3, 4'd1};
    vecs[18] = '{2'b00, 1'b1, 1'b1, 48, 1'b0, 1'b1, 4'd3, 4'd1};
    vecs[19] = '{2'b11, 1'b0, 1'b1, 15, 1'b0, 1'b1, 4'd3, 4'd1};
    vecs[20] = '{2'b11, 1'b0, 1'b1,  1, 1'b1, 1'b0, 4'd3, 4'd2}; // 64th hdr = 16th invalid
    vecs[21] = '{2'b00, 1'b0, 1'b0,  1, 1'b0, 1'b0, 4'd4, 4'd2};
    vecs[22] = '{2'b00, 1'b0, 1'b0, 31, 1'b0, 1'b0, 4'd4, 4'd2};

    do_reset();

    // table-driven lane-0 sequence; other lanes idle and must stay at zero
    for (int i = 0; i < 23; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        rxheader = '0;
        rxheader[1:0] = vecs[i].alt ? alt_hdr() : vecs[i].hdr;
        rxheader_valid = {3'b000, vecs[i].vld};
        tick();
      end
      check($sformatf("vec%0d_rxslip", i), 32'(rxslip), {31'd0, vecs[i].slip});
      check($sformatf("vec%0d_lock", i), 32'(block_lock), {31'd0, vecs[i].lock});
      check($sformatf("vec%0d_slip_count", i), 32'(slip_count), {28'd0, vecs[i].sc});
      check($sformatf("vec%0d_loss_count", i), 32'(lock_loss_count), {28'd0, vecs[i].ll});
    end

    // four lanes: lane 2 sees only invalid headers, the rest valid ones
    do_reset();
    rxheader_valid = 4'hF;
    for (int k = 1; k <= 600; k++) begin
      hv = alt_hdr();
      rxheader = {hv, 2'b11, hv, hv};
      tick();
      exp_slip = (((k - 1) % 33) == 0) ? 4'b0100 : 4'b0000;
      exp_lock = (k >= 64) ? 4'b1011 : 4'b0000;
      check($sformatf("ml_rxslip_c%0d", k), 32'(rxslip), 32'(exp_slip));
      check($sformatf("ml_lock_c%0d", k), 32'(block_lock), 32'(exp_lock));
      if (k == 100) begin
        check("ml_slip_count_c100", 32'(slip_count), 32'h0300);
        check("ml_loss_count_c100", 32'(lock_loss_count), 32'h0);
      end
    end
    check("ml_slip_count_saturated", 32'(slip_count), 32'h0F00);
    check("ml_loss_count_end", 32'(lock_loss_count), 32'h0);

    // reset while lane 2 is in WAIT
    rst = 1'b1;
    tick();
    check("rst_wait_rxslip", 32'(rxslip), 32'h0);
    check("rst_wait_lock", 32'(block_lock), 32'h0);
    check("rst_wait_slip_count", 32'(slip_count), 32'h0);
    check("rst_wait_loss_count", 32'(lock_loss_count), 32'h0);
    rst = 1'b0;
    rxheader_valid = '0;
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("post_rst_rxslip_%0d", k), 32'(rxslip), 32'h0);
    end

    // reset on the slip-pulse cycle
    rxheader = 8'b00_11_00_00;
    rxheader_valid = 4'b0100;
    tick();
    check("slip_cycle_rxslip", 32'(rxslip), 32'h4);
    rst = 1'b1;
    rxheader_valid = '0;
    tick();
    check("rst_slip_rxslip", 32'(rxslip), 32'h0);
    check("rst_slip_slip_count", 32'(slip_count), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("post_rst2_rxslip_%0d", k), 32'(rxslip), 32'h0);
    end
    check("post_rst2_slip_count", 32'(slip_count), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
